// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding and S-box/phase length constants for the RC4 core.
package rc4_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_KSA, ST_DROP, ST_PRGA} state_e;
    localparam int SBOX_DEPTH = 256;
    localparam int INIT_CYCLES = 256;
    localparam int KSA_CYCLES = 256;
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] KSA_LAST = 8'(KSA_CYCLES - 1);
endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256x8 permutation store, three combinational reads and a dual write for swaps.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] ra0_i,
    input  logic [7:0] ra1_i,
    input  logic [7:0] ra2_i,
    output logic [7:0] rd0_o,
    output logic [7:0] rd1_o,
    output logic [7:0] rd2_o,
    input  logic       we0_i,
    input  logic [7:0] wa0_i,
    input  logic [7:0] wd0_i,
    input  logic       we1_i,
    input  logic [7:0] wa1_i,
    input  logic [7:0] wd1_i
);
    logic [7:0] mem_q [SBOX_DEPTH];

    assign rd0_o = mem_q[ra0_i];
    assign rd1_o = mem_q[ra1_i];
    assign rd2_o = mem_q[ra2_i];

    // On a self-swap both ports carry the same value, so write order is irrelevant.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[wa0_i] <= wd0_i;
        if (we1_i) mem_q[wa1_i] <= wd1_i;
    end
endmodule

// File: rtl/rc4_stream_core.sv
// rc4_stream_core: RC4 key schedule and keystream generator with optional drop-n and ready/valid output.
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    parameter int DROP_N = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [8:0]                 key_length,
    input  logic                       stop,
    output logic [7:0]                 ks_data,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic                       busy,
    output logic                       key_err,
    output logic [31:0]                ks_count
);
    localparam logic [8:0] MAX_LEN = 9'(MAX_KEY_BYTES);
    localparam logic [11:0] DROP_LAST = 12'(DROP_N > 0 ? DROP_N - 1 : 0);

    state_e state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, data_q, data_d;
    logic [11:0] drop_q, drop_d;
    logic [MAX_KEY_BYTES*8-1:0] key_q, key_d;
    logic [8:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic valid_q, valid_d, err_q, err_d;
    logic [7:0] i_n, si, sj, kb, j1, ra0, ra2, rd2, wa0, wd0, out_byte;
    logic we0, we1, step;

    rc4_sbox u_sbox (
        .clk  (clk),
        .ra0_i(ra0),
        .ra1_i(j1),
        .ra2_i(ra2),
        .rd0_o(si),
        .rd1_o(sj),
        .rd2_o(rd2),
        .we0_i(we0),
        .wa0_i(wa0),
        .wd0_i(wd0),
        .we1_i(we1),
        .wa1_i(j1),
        .wd1_i(si)
    );

    assign i_n = i_q + 8'd1;
    assign kb = 8'(key_q >> {k_q, 3'b000});
    assign ra0 = (state_q == ST_KSA) ? i_q : i_n;
    assign j1 = (state_q == ST_KSA) ? j_q + si + kb : j_q + si;
    assign ra2 = si + sj;
    // Output index is read before the swap lands, so forward the two swapped entries.
    assign out_byte = (ra2 == i_n) ? sj : (ra2 == j1) ? si : rd2;
    assign step = !stop && (state_q == ST_DROP || (state_q == ST_PRGA && (!valid_q || ks_ready)));

    always_comb begin
        state_d = state_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        drop_d = drop_q;
        key_d = key_q;
        len_d = len_q;
        cnt_d = cnt_q;
        valid_d = valid_q;
        data_d = data_q;
        err_d = 1'b0;
        we0 = 1'b0;
        we1 = 1'b0;
        wa0 = i_n;
        wd0 = sj;
        unique case (state_q)
            ST_IDLE: begin
                if (start && key_length != 9'd0 && key_length <= MAX_LEN) begin
                    key_d = key;
                    len_d = key_length;
                    cnt_d = '0;
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                    state_d = ST_INIT;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_INIT: begin
                we0 = 1'b1;
                wa0 = i_q;
                wd0 = i_q;
                i_d = i_n;
                state_d = (i_q == INIT_LAST) ? ST_KSA : ST_INIT;
            end
            ST_KSA: begin
                we0 = 1'b1;
                we1 = 1'b1;
                wa0 = i_q;
                i_d = i_n;
                j_d = (i_q == KSA_LAST) ? 8'd0 : j1;
                k_d = ({1'b0, k_q} == len_q - 9'd1) ? 8'd0 : k_q + 8'd1;
                drop_d = '0;
                state_d = (i_q != KSA_LAST) ? ST_KSA : (DROP_N > 0) ? ST_DROP : ST_PRGA;
            end
            ST_DROP: begin
                if (step) begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                    i_d = i_n;
                    j_d = j1;
                    drop_d = drop_q + 12'd1;
                    state_d = (drop_q == DROP_LAST) ? ST_PRGA : ST_DROP;
                end
            end
            ST_PRGA: begin
                cnt_d = (valid_q && ks_ready) ? cnt_q + 32'd1 : cnt_q;
                if (step) begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                    i_d = i_n;
                    j_d = j1;
                    valid_d = 1'b1;
                    data_d = out_byte;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d = cnt_q;
            we0 = 1'b0;
            we1 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            drop_q <= '0;
            key_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            valid_q <= 1'b0;
            data_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            drop_q <= drop_d;
            key_q <= key_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end

    assign ks_data = data_q;
    assign ks_valid = valid_q;
    assign key_err = err_q;
    assign ks_count = cnt_q;
    assign busy = state_q != ST_IDLE;
endmodule

// File: doc/rc4_stream_core.md
RC4_STREAM_CORE -- requirements
Module: rc4_stream_core

Interface
REQ-001 Parameter MAX_KEY_BYTES, default 16: width of the key bus in bytes; legal range 1..256.
REQ-002 Parameter DROP_N, default 0: number of initial PRGA bytes generated and discarded after KSA (RC4-drop[n]); legal range 0..4095.
REQ-003 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request a new key schedule; sampled only in IDLE.
REQ-006 Port key, input, MAX_KEY_BYTES*8: key bytes; byte k sits at key[8*k +: 8], byte 0 in the LSBs; sampled when start is accepted.
REQ-007 Port key_length, input, 9: number of valid key bytes; sampled with key.
REQ-008 Port stop, input, 1: abandon the current key and return to IDLE.
REQ-009 Port ks_data, output, 8: keystream byte.
REQ-010 Port ks_valid, output, 1: ks_data holds a valid byte.
REQ-011 Port ks_ready, input, 1: consumer accepts ks_data when ks_valid and ks_ready are both high on a rising edge.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port key_err, output, 1: one-cycle pulse on rejection of start.
REQ-014 Port ks_count, output, 32: number of keystream bytes accepted since the last accepted start; wraps modulo 2^32.

Function
REQ-015 States SHALL be IDLE, INIT, KSA, DROP and PRGA.
REQ-016 In IDLE, start with 1 <= key_length <= MAX_KEY_BYTES SHALL latch key and key_length, clear ks_count, i and j, and move to INIT.
REQ-017 In IDLE, start with key_length 0 or above MAX_KEY_BYTES SHALL pulse key_err for one cycle and remain in IDLE.
REQ-018 INIT SHALL take exactly 256 cycles, writing S[n]=n for n=0..255, then enter KSA with i=0 and j=0.
REQ-019 KSA SHALL take exactly 256 cycles, one swap per cycle: j=j+S[i]+key[i mod key_length] (mod 256), swap S[i] and S[j], i=i+1.
REQ-020 After KSA, i and j SHALL be cleared, and the block SHALL enter DROP if DROP_N>0, otherwise PRGA.
REQ-021 Each PRGA step SHALL compute i=i+1, j=j+S[i], swap S[i] and S[j], and output S[(S[i]+S[j]) mod 256]; all arithmetic is 8-bit with natural wrap.
REQ-022 DROP SHALL perform exactly DROP_N PRGA steps with ks_valid held low, then enter PRGA.
REQ-023 In PRGA, ks_data/ks_valid SHALL be registered; ks_valid SHALL first rise exactly 513+DROP_N cycles after the start-accept edge.
REQ-024 While ks_valid is high and ks_ready is low, ks_data SHALL hold and the S, i and j state SHALL not advance.
REQ-025 With ks_ready held high, the block SHALL deliver one new byte per cycle with no bubbles.
REQ-026 Each accepted byte SHALL increment ks_count by 1.
REQ-027 stop SHALL be honoured in any state other than IDLE and takes priority over a same-cycle handshake. On the next edge the block SHALL be in IDLE with ks_valid=0, and the byte offered in that cycle SHALL not be counted.
REQ-028 start SHALL be ignored outside IDLE; start and stop asserted together in IDLE SHALL be treated as start alone.
REQ-029 ks_count SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state=IDLE, ks_valid=0, ks_data=0, busy=0, key_err=0, ks_count=0, i=0 and j=0, including mid-KSA or mid-PRGA.
REQ-031 S-box contents SHALL need no reset, since INIT rewrites them before use.

Structure
REQ-032 The state encoding, the S-box depth constant (256) and the INIT/KSA cycle-count constants SHALL live in the shared package rc4_pkg.
REQ-033 The S-box SHALL be a sub-module rc4_sbox: 256x8 register array with two combinational read ports, a third combinational read port for the output index, and a dual-write port for swaps.
REQ-034 The FSM, counters and handshake logic SHALL live in rc4_stream_core.

Verification
REQ-035 Key "Key" (4B 65 79), length 3, DROP_N=0, ks_ready=1: the first 8 bytes SHALL be EB 9F 77 81 B7 34 CA 72, with first ks_valid exactly 513 cycles after start.
REQ-036 Key "Wiki" (57 69 6B 69), random ks_ready backpressure: the bytes SHALL be 60 44 DB 6D 41 B7 with no loss or duplication, and ks_count=6 after 6 handshakes.
REQ-037 DROP_N=16, key "Secret": the stream SHALL equal the DROP_N=0 stream offset by 16 bytes, with first ks_valid at cycle 529.
REQ-038 key_length=0 and key_length=MAX_KEY_BYTES+1: each SHALL give a single-cycle key_err pulse, busy SHALL stay 0, and ks_valid SHALL never rise.
REQ-039 stop asserted mid-KSA and again mid-PRGA with a handshake in the same cycle: next cycle SHALL show IDLE, ks_valid=0 and an unchanged ks_count; a following start with key "Key" SHALL reproduce EB 9F 77.
REQ-040 rst_n pulsed low mid-PRGA: all outputs SHALL reach their reset values asynchronously, and a restart SHALL give correct keystream.
